// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with LATENCY wait cycles and a one-cycle ack.
// Optional range checking is enabled by defining DMEM_RANGE_CHECK_EN; by default upper address bits are ignored.
//
// state  | meaning
// S_IDLE | waiting for request, holding registers free
// S_WAIT | counting down wait cycles; access performed when count is 0
// S_RESP | ack (and err) asserted for exactly this cycle
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            hold_we;
  logic [3:0]      hold_mask;
  logic [31:0]     hold_data;
  logic [AW-1:0]   hold_idx;
  logic            hold_oor;
  logic            addr_oor;
  logic            do_access;
  logic            unused_addr;
  logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_oor    = |addr[31:AW+2];
  assign unused_addr = ^addr[1:0];
`else
  assign addr_oor    = 1'b0;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

  assign do_access = (state == S_WAIT) && (cnt == 4'd0);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'h0;
      hold_we   <= 1'b0;
      hold_mask <= 4'h0;
      hold_data <= 32'h0;
      hold_idx  <= '0;
      hold_oor  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            hold_we   <= we_re;
            hold_mask <= mask;
            hold_data <= store_data;
            hold_idx  <= addr[AW+1:2];
            hold_oor  <= addr_oor;
            cnt       <= 4'(LATENCY - 1);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (!hold_we) begin
              load_data <= hold_oor ? 32'h0 : mem[hold_idx];
            end
            ack   <= 1'b1;
            err   <= hold_oor;
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; reset forces S_IDLE so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (do_access && hold_we && !hold_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_mask[i]) begin
          mem[hold_idx][8*i +: 8] <= hold_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random accesses
// compared against a word-level reference model held in an associative array.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        ack;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mm [int];
  logic [31:0] last_ld = 32'h0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .we_re      (we_re),
    .mask       (mask),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .ack        (ack),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_apply(input bit we, input logic [3:0] m, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] exp_ld, output logic exp_err);
    logic [31:0] cur;
    int w;
    w       = int'((a >> 2) % DEPTH);
    exp_err = model_oor(a);
    if (exp_err) begin
      if (!we) last_ld = 32'h0;
    end else if (we) begin
      cur = mm.exists(w) ? mm[w] : 32'h0;
      for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
      mm[w] = cur;
    end else begin
      last_ld = mm[w];
    end
    exp_ld = last_ld;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input bit we, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, input bit keep_req, input string tag);
    logic [31:0] exp_ld;
    logic        exp_err;
    check({tag, ".idle_before"}, {31'b0, busy}, 32'h0);
    request = 1'b1; we_re = we; mask = m; addr = a; store_data = d;
    model_apply(we, m, a, d, exp_ld, exp_err);
    @(posedge clk);
    @(negedge clk);
    if (!keep_req) request = 1'b0;
    we_re = 1'($urandom); mask = 4'($urandom); addr = $urandom; store_data = $urandom;
    check({tag, ".busy_wait"}, {31'b0, busy}, 32'h1);
    check({tag, ".ack_wait"},  {31'b0, ack},  32'h0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        check({tag, ".ack_early"}, {31'b0, ack}, 32'h0);
        check({tag, ".busy_mid"},  {31'b0, busy}, 32'h1);
      end else begin
        check({tag, ".ack"},       {31'b0, ack}, 32'h1);
        check({tag, ".busy_resp"}, {31'b0, busy}, 32'h1);
        check({tag, ".err"},       {31'b0, err}, {31'b0, exp_err});
        check({tag, ".load_data"}, load_data, exp_ld);
      end
    end
    @(negedge clk);
    check({tag, ".ack_after"},  {31'b0, ack},  32'h0);
    check({tag, ".busy_after"}, {31'b0, busy}, 32'h0);
    check({tag, ".err_after"},  {31'b0, err},  32'h0);
  endtask

  initial begin
    int idx;
    logic [31:0] a;
    rst = 1'b0; request = 1'b0; we_re = 1'b0; mask = 4'h0; addr = 32'h0; store_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.ack",  {31'b0, ack},  32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.ack",       {31'b0, ack},  32'h0);
    check("idle.busy",      {31'b0, busy}, 32'h0);
    check("idle.err",       {31'b0, err},  32'h0);
    check("idle.load_data", load_data,     32'h0);

    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
    access(1'b0, 4'h0, 32'h10, 32'h0,        1'b0, "rd10");
    check("rd10.const", load_data, 32'hDEADBEEF);

    access(1'b1, 4'hF,    32'h20, 32'h11223344, 1'b0, "pre20");
    access(1'b1, 4'b0100, 32'h22, 32'h00AA0000, 1'b0, "bytewr");
    access(1'b0, 4'hF,    32'h20, 32'h0,        1'b0, "byterd");
    check("byterd.const", load_data, 32'h11AA3344);
    access(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 1'b0, "mask0");
    access(1'b0, 4'h0,    32'h20, 32'h0,        1'b0, "mask0rd");

    // Request held high across back-to-back accesses, including write-then-read of one word.
    access(1'b1, 4'hF, 32'h24, 32'hA5A5_0001, 1'b1, "hold0");
    access(1'b0, 4'h0, 32'h24, 32'h0,         1'b1, "hold1");
    access(1'b1, 4'h3, 32'h24, 32'h0000_7777, 1'b1, "hold2");
    access(1'b0, 4'h0, 32'h24, 32'h0,         1'b1, "hold3");
    access(1'b0, 4'h0, 32'h10, 32'h0,         1'b0, "hold4");

    // Reset during an accepted write: write must not land and no ack may appear.
    access(1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 1'b0, "pre30");
    request = 1'b1; we_re = 1'b1; mask = 4'hF; addr = 32'h30; store_data = 32'h0BADBEEF;
    @(posedge clk);
    @(negedge clk);
    request = 1'b0;
    check("midrst.busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check("midrst.busy", {31'b0, busy}, 32'h0);
    check("midrst.ld",   load_data,     32'h0);
    last_ld = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("midrst.no_ack", {31'b0, ack}, 32'h0);
    end
    access(1'b0, 4'h0, 32'h30, 32'h0, 1'b0, "midrst.rd30");
    check("midrst.const", load_data, 32'hCAFEF00D);

`ifdef DMEM_RANGE_CHECK_EN
    access(1'b0, 4'h0, 32'h1000, 32'h0,        1'b0, "oor.rd");
    check("oor.ld0", load_data, 32'h0);
    access(1'b1, 4'hF, 32'h1010, 32'h12345678, 1'b0, "oor.wr");
    access(1'b0, 4'h0, 32'h10,   32'h0,        1'b0, "oor.rd10");
    check("oor.keep", load_data, 32'hDEADBEEF);
`else
    access(1'b1, 4'hF, 32'h1004, 32'h5A5A1234, 1'b0, "wrap.wr");
    access(1'b0, 4'h0, 32'h4,    32'h0,        1'b0, "wrap.rd");
    check("wrap.const", load_data, 32'h5A5A1234);
`endif

    for (int i = 0; i < 8; i++) access(1'b1, 4'hF, 32'h40 + 32'(i) * 4, $urandom, 1'b0, "rinit");
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 7));
      a = 32'h40 + 32'(idx) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 * 32'($urandom_range(1, 15)));
      access(1'($urandom), 4'($urandom), a, $urandom, 1'($urandom), "rand");
    end
    request = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
